z80_bus_ctrl: RTL

Z80_BUS_CTRL -- requirements
Module: z80_bus_ctrl

---
 rtl/z80_bus_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/z80_bus_ctrl.sv
// Z80 bus controller: decodes CPU memory and I/O cycles into ROM, RAM and
// I/O-channel strobes, returns read data, holds the RAM bank / ROM overlay
// control register, and inserts per-region wait states.
//
// Handshake: the CPU samples wait_n; while wait_n=0 (FSM in STALL) the CPU
// keeps its bus cycle open and all strobes and cpu_din stay valid. An access
// is accepted (its wait count loaded) only on the first edge it is seen after
// a cycle with no qualifying access, so a long HOLD never re-arms the stall.
module z80_bus_ctrl #(
    parameter int          ROM_BITS  = 13,
    parameter int          NUM_IO    = 4,
    parameter logic [7:0]  IO_BASE   = 8'h80,
    parameter logic [7:0]  CTRL_PORT = 8'hF0,
    parameter int          ROM_WAIT  = 1,
    parameter int          RAM_WAIT  = 0,
    parameter int          IO_WAIT   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           addr,
    input  logic                  mreq_n,
    input  logic                  iorq_n,
    input  logic                  rd_n,
    input  logic                  wr_n,
    input  logic                  m1_n,
    input  logic                  rfsh_n,
    input  logic [7:0]            cpu_dout,
    output logic [7:0]            cpu_din,
    input  logic [7:0]            rom_data,
    input  logic [7:0]            ram_data,
    input  logic [8*NUM_IO-1:0]   io_data,
    output logic                  rom_rd,
    output logic                  ram_rd,
    output logic                  ram_wr,
    output logic [NUM_IO-1:0]     io_rd,
    output logic [NUM_IO-1:0]     io_wr,
    output logic                  io_sel,
    output logic [3:0]            ram_bank,
    output logic                  rom_overlay,
    output logic                  wait_n,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STALL = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                qual_q;

    logic                mem_acc, io_acc;
    logic                rom_sel, ram_sel, ctrl_sel;
    logic [NUM_IO-1:0]   chan_hit;
    logic                qual, start, bus_idle;
    logic [2:0]          wait_cnt;

    // Control-register bits 3:1 carry no function.
    logic                unused_bits;
    assign unused_bits = ^cpu_dout[3:1];

    // Address decode: classify the current bus cycle into a region.
    always_comb begin
        mem_acc  = ~mreq_n & rfsh_n;
        io_acc   = ~iorq_n & m1_n;
        rom_sel  = mem_acc & rom_overlay & ((addr >> ROM_BITS) == 16'd0);
        ram_sel  = mem_acc & ~rom_sel;
        ctrl_sel = io_acc & (addr[7:0] == CTRL_PORT);
        chan_hit = '0;
        for (int k = 0; k < NUM_IO; k++) begin
            if (io_acc && (addr[7:1] == (IO_BASE[7:1] + 7'(k)))) begin
                chan_hit[k] = 1'b1;
            end
        end
    end

    assign rom_rd = rom_sel & ~rd_n;
    assign ram_rd = ram_sel & ~rd_n;
    assign ram_wr = ram_sel & ~wr_n;
    assign io_rd  = chan_hit & {NUM_IO{~rd_n}};
    assign io_wr  = chan_hit & {NUM_IO{~wr_n}};
    assign io_sel = addr[0];

    // Read-data mux; intack, refresh, unmapped ports and idle read as 0xFF.
    always_comb begin
        cpu_din = 8'hFF;
        if (rom_sel) begin
            cpu_din = rom_data;
        end else if (ram_sel) begin
            cpu_din = ram_data;
        end else if (ctrl_sel) begin
            cpu_din = {ram_bank, 3'b000, rom_overlay};
        end else begin
            for (int k = 0; k < NUM_IO; k++) begin
                if (chan_hit[k]) begin
                    cpu_din = io_data[8*k +: 8];
                end
            end
        end
    end

    // Control register: bank reloads every edge of a CTRL_PORT write; overlay only clears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_bank    <= 4'd0;
            rom_overlay <= 1'b1;
        end else if (ctrl_sel && !wr_n) begin
            ram_bank <= cpu_dout[7:4];
            if (cpu_dout[0]) begin
                rom_overlay <= 1'b0;
            end
        end
    end

    // Wait-count selection and access-start detection.
    always_comb begin
        qual     = mem_acc | (|chan_hit) | ctrl_sel;
        start    = qual & ~qual_q;
        bus_idle = mreq_n & iorq_n;
        if (rom_sel) begin
            wait_cnt = 3'(ROM_WAIT);
        end else if (ram_sel) begin
            wait_cnt = 3'(RAM_WAIT);
        end else begin
            wait_cnt = 3'(IO_WAIT);
        end
    end

    // Wait FSM state, counter and previous-cycle access flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            qual_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qual_q  <= qual;
        end
    end

    // Wait FSM next state: bus release wins, then a fresh start, then stall countdown.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus_idle) begin
            state_d = S_IDLE;
        end else if (start) begin
            cnt_d   = wait_cnt;
            state_d = (wait_cnt == 3'd0) ? S_HOLD : S_STALL;
        end else if (state_q == S_STALL) begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) begin
                state_d = S_HOLD;
            end
        end
    end

    assign wait_n    = (state_q != S_STALL);
    assign fsm_state = state_q;

endmodule
